// File: rtl/tdp_ram_pkg.sv
// Shared definitions for the clearable true dual-port RAM: FSM encoding,
// read latency bounds and the write-lane count helper.
package tdp_ram_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam int unsigned READ_LATENCY_MIN = 1;
    localparam int unsigned READ_LATENCY_MAX = 3;

    function automatic int unsigned lane_count(input int unsigned mem_width,
                                               input int unsigned strobe_width);
        return mem_width / strobe_width;
    endfunction

endpackage

// File: rtl/tdp_ram_out_pipe.sv
// Output register pipeline (STAGES >= 1) with asynchronous reset to zero.
module tdp_ram_out_pipe #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[STAGES-1];

endmodule

// File: rtl/tdp_ram_clr.sv
// True dual-port RAM with byte-lane writes on port A, read-only port B and a
// hardware clear sweep. Optional port B write-first bypass: TDP_RAM_CLR_BYPASS_EN.
module tdp_ram_clr
    import tdp_ram_pkg::*;
#(
    parameter int unsigned MEM_WIDTH          = 16,
    parameter int unsigned WRITE_STROBE_WIDTH = 4,
    parameter int unsigned ADDR_WIDTH         = 8,
    parameter int unsigned READ_LATENCY       = 1,
    localparam int unsigned WRITE_MASK_SIZE   = lane_count(MEM_WIDTH, WRITE_STROBE_WIDTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [MEM_WIDTH-1:0]       writeData,
    input  logic                       write,
    input  logic [ADDR_WIDTH-1:0]      writeAddr,
    input  logic [WRITE_MASK_SIZE-1:0] writeMask,
    output logic [MEM_WIDTH-1:0]       writeDataOut,
    input  logic [ADDR_WIDTH-1:0]      readAddr,
    output logic [MEM_WIDTH-1:0]       readData,
    input  logic [MEM_WIDTH-1:0]       clearValue,
    input  logic                       clear,
    output logic                       clearBusy
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    generate
        if (READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_lat
            $error("tdp_ram_clr: READ_LATENCY out of range");
        end
        if (MEM_WIDTH % WRITE_STROBE_WIDTH != 0) begin : g_bad_lane
            $error("tdp_ram_clr: MEM_WIDTH not a multiple of WRITE_STROBE_WIDTH");
        end
    endgenerate

    logic [MEM_WIDTH-1:0]       r_mem [DEPTH];
    logic [0:0]                 r_state;
    logic [ADDR_WIDTH:0]        r_cnt;
    logic [MEM_WIDTH-1:0]       r_clr_val;
    logic [MEM_WIDTH-1:0]       r_rd_a;
    logic [MEM_WIDTH-1:0]       r_rd_b;

    logic [ADDR_WIDTH:0]        w_cnt_inc;
    logic                       w_sweep;
    logic                       w_we;
    logic [ADDR_WIDTH-1:0]      w_waddr;
    logic [MEM_WIDTH-1:0]       w_wdata;
    logic [WRITE_MASK_SIZE-1:0] w_wmask;
    logic [MEM_WIDTH-1:0]       w_rd_b;

    assign w_sweep   = (r_state == ST_CLEAR);
    assign clearBusy = w_sweep;
    assign w_cnt_inc = r_cnt + {{ADDR_WIDTH{1'b0}}, 1'b1};

    // The sweep owns the write port; user writes are dropped while it runs.
    always_comb begin
        if (w_sweep) begin
            w_we    = 1'b1;
            w_waddr = r_cnt[ADDR_WIDTH-1:0];
            w_wdata = r_clr_val;
            w_wmask = '1;
        end else begin
            w_we    = write;
            w_waddr = writeAddr;
            w_wdata = writeData;
            w_wmask = writeMask;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_clr_val <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clear) begin
                        r_state   <= ST_CLEAR;
                        r_cnt     <= '0;
                        r_clr_val <= clearValue;
                    end
                end
                ST_CLEAR: begin
                    // Carry into the extra counter bit marks the last address.
                    if (w_cnt_inc[ADDR_WIDTH]) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int i = 0; i < WRITE_MASK_SIZE; i++) begin
                if (w_wmask[i]) begin
                    r_mem[w_waddr][i*WRITE_STROBE_WIDTH +: WRITE_STROBE_WIDTH] <=
                        w_wdata[i*WRITE_STROBE_WIDTH +: WRITE_STROBE_WIDTH];
                end
            end
        end
    end

`ifdef TDP_RAM_CLR_BYPASS_EN
    always_comb begin
        w_rd_b = r_mem[readAddr];
        if (w_we && (readAddr == w_waddr)) begin
            for (int i = 0; i < WRITE_MASK_SIZE; i++) begin
                if (w_wmask[i]) begin
                    w_rd_b[i*WRITE_STROBE_WIDTH +: WRITE_STROBE_WIDTH] =
                        w_wdata[i*WRITE_STROBE_WIDTH +: WRITE_STROBE_WIDTH];
                end
            end
        end
    end
`else
    assign w_rd_b = r_mem[readAddr];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_a <= '0;
            r_rd_b <= '0;
        end else begin
            r_rd_a <= r_mem[writeAddr];
            r_rd_b <= w_rd_b;
        end
    end

    generate
        if (READ_LATENCY > READ_LATENCY_MIN) begin : g_pipe
            tdp_ram_out_pipe #(
                .WIDTH  (MEM_WIDTH),
                .STAGES (READ_LATENCY - 1)
            ) u_pipe_a (
                .i_clk   (clk),
                .i_reset (reset),
                .i_data  (r_rd_a),
                .o_data  (writeDataOut)
            );
            tdp_ram_out_pipe #(
                .WIDTH  (MEM_WIDTH),
                .STAGES (READ_LATENCY - 1)
            ) u_pipe_b (
                .i_clk   (clk),
                .i_reset (reset),
                .i_data  (r_rd_b),
                .o_data  (readData)
            );
        end else begin : g_no_pipe
            assign writeDataOut = r_rd_a;
            assign readData     = r_rd_b;
        end
    endgenerate

endmodule
